// File: rtl/sram_bus_responder.sv
// CPU data-bus responder driving a 32-bit asynchronous SRAM (two x16 chips).
// Every request is stretched into a timed SRAM cycle and answered with a one-cycle ack.
module sram_bus_responder #(
    parameter int unsigned ADDR_WIDTH  = 20,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           bus_address,
    input  logic [3:0]            bus_byteenable,
    input  logic                  bus_read,
    input  logic                  bus_write,
    input  logic [31:0]           bus_wrdata,
    output logic [31:0]           bus_rddata,
    output logic                  bus_stall,
    output logic                  bus_ack,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_data_o,
    output logic                  ram_data_oe,
    input  logic [31:0]           ram_data_i,
    output logic                  ram_ce_n,
    output logic                  ram_oe_n,
    output logic                  ram_we_n,
    output logic [3:0]            ram_be_n
);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWrSetup,
        StWrPulse,
        StWrHold,
        StDone
    } state_t;

    localparam logic [3:0] CntLoad = 4'(WAIT_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;

    // Byte-offset and out-of-range address bits carry no meaning for the SRAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus_address[31:ADDR_WIDTH+2], bus_address[1:0]};

    assign bus_stall = (bus_read | bus_write) & (state != StDone);

    // SRAM strobes are registered: each is set on the edge that enters the state using it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            cnt         <= 4'd0;
            bus_ack     <= 1'b0;
            bus_rddata  <= 32'd0;
            ram_ce_n    <= 1'b1;
            ram_oe_n    <= 1'b1;
            ram_we_n    <= 1'b1;
            ram_be_n    <= 4'hF;
            ram_data_oe <= 1'b0;
            ram_addr    <= '0;
            ram_data_o  <= 32'd0;
        end else begin
            bus_ack <= 1'b0;
            case (state)
                StIdle: begin
                    if (bus_read || bus_write) begin
                        ram_addr   <= bus_address[ADDR_WIDTH+1:2];
                        ram_data_o <= bus_wrdata;
                        if (bus_read) begin
                            // A simultaneous write is dropped; the read's ack covers it.
                            state    <= StRead;
                            cnt      <= CntLoad;
                            ram_ce_n <= 1'b0;
                            ram_oe_n <= 1'b0;
                            ram_be_n <= 4'h0;
                        end else if (bus_byteenable == 4'h0) begin
                            state   <= StDone;
                            bus_ack <= 1'b1;
                        end else begin
                            state       <= StWrSetup;
                            ram_ce_n    <= 1'b0;
                            ram_data_oe <= 1'b1;
                            ram_be_n    <= ~bus_byteenable;
                        end
                    end
                end
                StRead: begin
                    if (cnt == 4'd0) begin
                        bus_rddata <= ram_data_i;
                        state      <= StDone;
                        bus_ack    <= 1'b1;
                        ram_ce_n   <= 1'b1;
                        ram_oe_n   <= 1'b1;
                        ram_be_n   <= 4'hF;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                StWrSetup: begin
                    state    <= StWrPulse;
                    cnt      <= CntLoad;
                    ram_we_n <= 1'b0;
                end
                StWrPulse: begin
                    if (cnt == 4'd0) begin
                        state    <= StWrHold;
                        ram_we_n <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                StWrHold: begin
                    state       <= StDone;
                    bus_ack     <= 1'b1;
                    ram_ce_n    <= 1'b1;
                    ram_data_oe <= 1'b0;
                    ram_be_n    <= 4'hF;
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_bus_responder.sv
// Bench for sram_bus_responder: behavioural SRAM plus a word-level memory model
// that predicts read data, latency and strobe counts for directed and random traffic.
module tb_sram_bus_responder;

    localparam int W  = 2;
    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   bus_address = '0;
    logic [3:0]    bus_byteenable = '0;
    logic          bus_read = 1'b0;
    logic          bus_write = 1'b0;
    logic [31:0]   bus_wrdata = '0;
    logic [31:0]   bus_rddata;
    logic          bus_stall;
    logic          bus_ack;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_data_o;
    logic          ram_data_oe;
    logic [31:0]   ram_data_i;
    logic          ram_ce_n;
    logic          ram_oe_n;
    logic          ram_we_n;
    logic [3:0]    ram_be_n;

    always #5 clk = ~clk;

    sram_bus_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus_address   (bus_address),
        .bus_byteenable(bus_byteenable),
        .bus_read      (bus_read),
        .bus_write     (bus_write),
        .bus_wrdata    (bus_wrdata),
        .bus_rddata    (bus_rddata),
        .bus_stall     (bus_stall),
        .bus_ack       (bus_ack),
        .ram_addr      (ram_addr),
        .ram_data_o    (ram_data_o),
        .ram_data_oe   (ram_data_oe),
        .ram_data_i    (ram_data_i),
        .ram_ce_n      (ram_ce_n),
        .ram_oe_n      (ram_oe_n),
        .ram_we_n      (ram_we_n),
        .ram_be_n      (ram_be_n)
    );

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Physical SRAM: 1024 words, written while CE and WE are low, read while CE and OE are low.
    logic [31:0] sram    [0:1023];
    logic [31:0] exp_mem [0:1023];
    logic        poke = 1'b0;
    logic [9:0]  poke_idx = '0;
    logic [31:0] poke_val = '0;

    assign ram_data_i = (!ram_ce_n && !ram_oe_n) ? sram[ram_addr[9:0]] : 32'h0BAD_0BAD;

    always @(posedge clk) begin
        if (poke) sram[poke_idx] <= poke_val;
        else if (!ram_ce_n && !ram_we_n)
            sram[ram_addr[9:0]] <= merge(sram[ram_addr[9:0]], ram_data_o, ~ram_be_n);
    end

    int   vectors = 0;
    int   miscompares = 0;
    int   dbl_ack = 0;
    logic prev_ack = 1'b0;

    always @(negedge clk) begin
        if (bus_ack && prev_ack) dbl_ack <= dbl_ack + 1;
        prev_ack <= bus_ack;
    end

    typedef struct {
        int          lat;
        int          ce_low;
        int          oe_low;
        int          we_low;
        int          first_ce;
        int          first_we;
        logic [19:0] addr;
        logic [3:0]  be_n;
        bit          stall_ok;
    } obs_t;

    logic [31:0] last_rd = '0;

    task automatic load_word(input logic [9:0] idx, input logic [31:0] val);
        poke = 1'b1; poke_idx = idx; poke_val = val;
        exp_mem[idx] = val;
        @(posedge clk); #1;
        poke = 1'b0;
    endtask

    // Drives one request from cycle 0 until ack, recording what the SRAM pins did.
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [3:0] be, input logic [31:0] wd, output obs_t o);
        logic got;
        o.lat = -1; o.ce_low = 0; o.oe_low = 0; o.we_low = 0;
        o.first_ce = -1; o.first_we = -1; o.addr = '0; o.be_n = 4'hF; o.stall_ok = 1'b1;
        bus_read = rd; bus_write = wr; bus_address = a; bus_byteenable = be; bus_wrdata = wd;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            got = bus_ack;
            if (!ram_ce_n) begin
                if (o.first_ce < 0) o.first_ce = c;
                o.ce_low++; o.addr = ram_addr; o.be_n = ram_be_n;
            end
            if (!ram_oe_n) o.oe_low++;
            if (!ram_we_n) begin
                if (o.first_we < 0) o.first_we = c;
                o.we_low++;
            end
            if (got) begin
                o.lat = c;
                if (bus_stall) o.stall_ok = 1'b0;
            end else if (!bus_stall) o.stall_ok = 1'b0;
            @(posedge clk); #1;
            if (got) break;
        end
        bus_read = 1'b0; bus_write = 1'b0;
    endtask

    task automatic test_reset();
        vectors++; if (bus_ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack got %b want 0", bus_ack); end
        vectors++; if (bus_rddata !== 32'd0) begin miscompares++; $display("FAIL reset_rddata got %h want 0", bus_rddata); end
        vectors++; if ({ram_ce_n, ram_oe_n, ram_we_n} !== 3'b111) begin miscompares++; $display("FAIL reset_strobes got %b want 111", {ram_ce_n, ram_oe_n, ram_we_n}); end
        vectors++; if (ram_be_n !== 4'hF) begin miscompares++; $display("FAIL reset_be_n got %h want f", ram_be_n); end
        vectors++; if (ram_data_oe !== 1'b0) begin miscompares++; $display("FAIL reset_data_oe got %b want 0", ram_data_oe); end
        vectors++; if ({ram_addr, ram_data_o} !== 52'd0) begin miscompares++; $display("FAIL reset_addr_data got %h/%h want 0/0", ram_addr, ram_data_o); end
        vectors++; if (bus_stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b want 0", bus_stall); end
    endtask

    task automatic test_read();
        obs_t o;
        load_word(10'h010, 32'h1234_5678);
        run_txn(1'b1, 1'b0, 32'h8000_0040, 4'hF, 32'h0, o);
        last_rd = exp_mem[10'h010];
        vectors++; if (o.addr !== 20'h00010) begin miscompares++; $display("FAIL read_addr got %h want 00010", o.addr); end
        vectors++; if (o.oe_low !== W) begin miscompares++; $display("FAIL read_oe_cycles got %0d want %0d", o.oe_low, W); end
        vectors++; if (o.lat !== W + 1) begin miscompares++; $display("FAIL read_latency got %0d want %0d", o.lat, W + 1); end
        vectors++; if (o.stall_ok !== 1'b1) begin miscompares++; $display("FAIL read_stall got bad want stall until ack"); end
        vectors++; if (bus_rddata !== 32'h1234_5678) begin miscompares++; $display("FAIL read_data got %h want 12345678", bus_rddata); end
    endtask

    task automatic test_byte_write();
        obs_t o;
        load_word(10'h011, 32'h1122_3344);
        run_txn(1'b0, 1'b1, 32'h0000_0044, 4'b0100, 32'hAABB_CCDD, o);
        exp_mem[10'h011] = merge(exp_mem[10'h011], 32'hAABB_CCDD, 4'b0100);
        vectors++; if (o.we_low !== W) begin miscompares++; $display("FAIL bw_we_cycles got %0d want %0d", o.we_low, W); end
        vectors++; if (o.first_we !== o.first_ce + 1 || o.ce_low !== W + 2) begin miscompares++; $display("FAIL bw_setup_hold got ce@%0d we@%0d ce_len %0d want we one after ce, ce_len %0d", o.first_ce, o.first_we, o.ce_low, W + 2); end
        vectors++; if (o.be_n !== 4'b1011) begin miscompares++; $display("FAIL bw_be_n got %b want 1011", o.be_n); end
        vectors++; if (o.lat !== W + 3) begin miscompares++; $display("FAIL bw_latency got %0d want %0d", o.lat, W + 3); end
        vectors++; if (bus_rddata !== last_rd) begin miscompares++; $display("FAIL bw_rddata_held got %h want %h", bus_rddata, last_rd); end
        run_txn(1'b1, 1'b0, 32'h0000_0044, 4'hF, 32'h0, o);
        last_rd = exp_mem[10'h011];
        vectors++; if (bus_rddata !== 32'h11BB_3344) begin miscompares++; $display("FAIL bw_readback got %h want 11bb3344", bus_rddata); end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        int d0;
        d0 = dbl_ack;
        run_txn(1'b0, 1'b1, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF, o);
        exp_mem[10'h040] = 32'hDEAD_BEEF;
        run_txn(1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0, o);
        last_rd = exp_mem[10'h040];
        vectors++; if (bus_rddata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL b2b_data got %h want deadbeef", bus_rddata); end
        vectors++; if (o.lat !== W + 1) begin miscompares++; $display("FAIL b2b_latency got %0d want %0d", o.lat, W + 1); end
        vectors++; if (dbl_ack !== d0) begin miscompares++; $display("FAIL b2b_double_ack got %0d want %0d", dbl_ack, d0); end
    endtask

    task automatic test_zero_byte();
        obs_t o;
        run_txn(1'b0, 1'b1, 32'h0000_0300, 4'h0, 32'hFFFF_FFFF, o);
        vectors++; if (o.ce_low !== 0) begin miscompares++; $display("FAIL zb_ce got %0d low cycles want 0", o.ce_low); end
        vectors++; if (o.lat !== 1) begin miscompares++; $display("FAIL zb_latency got %0d want 1", o.lat); end
        run_txn(1'b1, 1'b0, 32'h0000_0300, 4'hF, 32'h0, o);
        last_rd = exp_mem[10'h0C0];
        vectors++; if (bus_rddata !== last_rd) begin miscompares++; $display("FAIL zb_unchanged got %h want %h", bus_rddata, last_rd); end
    endtask

    task automatic test_reset_mid_write();
        obs_t o;
        int   acks;
        bit   reached;
        reached = 1'b0;
        acks = 0;
        bus_write = 1'b1; bus_address = 32'h0000_03F0; bus_byteenable = 4'hF;
        bus_wrdata = $urandom;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!ram_we_n) begin reached = 1'b1; break; end
        end
        vectors++; if (reached !== 1'b1) begin miscompares++; $display("FAIL rmw_pulse got no we pulse want we low"); end
        #2 rst = 1'b1;
        #1;
        vectors++; if ({ram_we_n, ram_ce_n, ram_data_oe} !== 3'b110) begin miscompares++; $display("FAIL rmw_async got we/ce/oe %b want 110", {ram_we_n, ram_ce_n, ram_data_oe}); end
        bus_write = 1'b0;
        repeat (2) begin @(negedge clk); if (bus_ack) acks++; end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin @(negedge clk); if (bus_ack) acks++; end
        vectors++; if (acks !== 0) begin miscompares++; $display("FAIL rmw_no_ack got %0d acks want 0", acks); end
        last_rd = 32'd0;
        vectors++; if (bus_rddata !== last_rd) begin miscompares++; $display("FAIL rmw_rddata_cleared got %h want 0", bus_rddata); end
        // The aborted write may or may not have landed; adopt whatever the SRAM now holds.
        exp_mem[10'h0FC] = sram[10'h0FC];
        @(posedge clk); #1;
        run_txn(1'b1, 1'b0, 32'h0000_0044, 4'hF, 32'h0, o);
        last_rd = exp_mem[10'h011];
        vectors++; if (o.lat !== W + 1 || bus_rddata !== last_rd) begin miscompares++; $display("FAIL rmw_recover got lat %0d data %h want lat %0d data %h", o.lat, bus_rddata, W + 1, last_rd); end
    endtask

    task automatic test_simultaneous();
        obs_t o;
        int   acks;
        acks = 0;
        run_txn(1'b1, 1'b1, 32'h0000_0200, 4'hF, 32'h5555_AAAA, o);
        last_rd = exp_mem[10'h080];
        vectors++; if (o.we_low !== 0) begin miscompares++; $display("FAIL sim_we got %0d low cycles want 0", o.we_low); end
        vectors++; if (o.lat !== W + 1) begin miscompares++; $display("FAIL sim_latency got %0d want %0d", o.lat, W + 1); end
        vectors++; if (bus_rddata !== last_rd) begin miscompares++; $display("FAIL sim_data got %h want %h", bus_rddata, last_rd); end
        repeat (3) begin @(negedge clk); if (bus_ack) acks++; end
        @(posedge clk); #1;
        vectors++; if (acks !== 0) begin miscompares++; $display("FAIL sim_single_ack got %0d extra acks want 0", acks); end
    endtask

    task automatic test_random();
        obs_t        o;
        logic [31:0] a, wd;
        logic [9:0]  idx;
        logic [3:0]  be;
        logic        rd, wr;
        int          kind, exp_lat;
        for (int n = 0; n < 40; n++) begin
            idx = 10'($urandom_range(0, 1023));
            a = $urandom;
            a[21:12] = '0;
            a[11:2] = idx;
            wd = $urandom;
            kind = $urandom_range(0, 3);
            rd = (kind == 0 || kind == 3);
            wr = (kind != 0);
            be = (kind == 2) ? 4'h0 : 4'($urandom_range(1, 15));
            run_txn(rd, wr, a, be, wd, o);
            if (rd) begin
                exp_lat = W + 1;
                last_rd = exp_mem[idx];
            end else begin
                exp_lat = (be == 4'h0) ? 1 : W + 3;
                exp_mem[idx] = merge(exp_mem[idx], wd, be);
            end
            vectors++; if (o.lat !== exp_lat) begin miscompares++; $display("FAIL rnd%0d_latency got %0d want %0d", n, o.lat, exp_lat); end
            vectors++; if (bus_rddata !== last_rd) begin miscompares++; $display("FAIL rnd%0d_rddata got %h want %h", n, bus_rddata, last_rd); end
            vectors++; if (o.we_low !== ((!rd && be != 4'h0) ? W : 0) || o.oe_low !== (rd ? W : 0)) begin miscompares++; $display("FAIL rnd%0d_strobes got we %0d oe %0d", n, o.we_low, o.oe_low); end
            if (o.ce_low > 0) begin
                vectors++; if (o.addr !== 20'(idx) || o.be_n !== (rd ? 4'h0 : ~be)) begin miscompares++; $display("FAIL rnd%0d_pins got addr %h be_n %b want %h %b", n, o.addr, o.be_n, 20'(idx), rd ? 4'h0 : ~be); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) load_word(10'(i), $urandom);
        @(posedge clk); #1;
        test_reset();
        rst = 1'b0;
        test_read();
        test_byte_write();
        test_back_to_back();
        test_zero_byte();
        test_reset_mid_write();
        test_simultaneous();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
